prng_share_arbiter: RTL and testbench

//  Sequences the Trivium PRNG adapter: issues its seed/reset, waits out initialisation and re-seeds on request.

---
 rtl/prng_share_arbiter.sv | 103 ++++++++++
 tb/tb_prng_share_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prng_share_arbiter.sv
// Sequences the Trivium PRNG adapter (seed load, init wait, reseed) and deals its
// word stream round-robin to NUM_REQ consumers, at most one consumer per word.
module prng_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 64,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        seed_in,
  input  logic               reseed,
  output logic               trv_rst,
  output logic [63:0]        trv_seed,
  input  logic [DW-1:0]      trv_data,
  input  logic               trv_valid,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [DW-1:0]      rnd_data,
  output logic               busy,
  output logic [CNT_W-1:0]   issue_cnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_SEED,
    ST_WAIT,
    ST_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [63:0]       seed_q;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     winner;
  logic [PW-1:0]     next_ptr;
  logic              found;
  logic              grant_en;
  logic [PW-1:0]     cand [NUM_REQ];

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_SEED: state_d = ST_WAIT;
      ST_WAIT: if (trv_valid) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_SEED;
    endcase
    if (reseed) state_d = ST_SEED;
  end

  // Candidate k is the requester k places after rr_ptr, wrapped modulo NUM_REQ.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
    logic [PW:0] sum;
    assign sum     = {1'b0, rr_ptr} + (PW+1)'(k);
    assign cand[k] = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[cand[k]]) begin
        found  = 1'b1;
        winner = cand[k];
      end
    end
  end

  assign next_ptr = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
  // A reseed wins over arbitration so no word is issued from a PRNG about to restart.
  assign grant_en = (state_q == ST_RUN) && !reseed && trv_valid && found;

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: the data word is reset too, so rnd_data is a known 0 before any grant.
      state_q   <= ST_SEED;
      seed_q    <= seed_in;
      rr_ptr    <= '0;
      gnt       <= '0;
      rnd_data  <= '0;
      issue_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (reseed) seed_q <= seed_in;
      if (grant_en) begin
        gnt       <= NUM_REQ'(1) << winner;
        rnd_data  <= trv_data;
        rr_ptr    <= next_ptr;
        issue_cnt <= issue_cnt + CNT_W'(1);
      end else begin
        gnt <= '0;
      end
    end
  end

  assign trv_rst  = (state_q == ST_SEED);
  assign trv_seed = seed_q;
  assign busy     = (state_q != ST_RUN);

endmodule

// File: tb/tb_prng_share_arbiter.sv
// Bench for prng_share_arbiter: a PRNG adapter model feeds the DUT, and a cycle-level
// reference model of the sequencing and round-robin rules predicts every output.
module tb_prng_share_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int DW       = 64;
  localparam int CNT_W    = 4;
  localparam int INIT_CYC = 19;
  localparam int VW       = NUM_REQ + DW + CNT_W + 2 + 64;
  localparam int PH_SEED  = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_RUN   = 2;
  localparam logic [63:0] GOLD = 64'h9E37_79B9_7F4A_7C15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               reseed = 1'b0;
  logic [63:0]        seed_in = '0;
  logic [NUM_REQ-1:0] req = '0;
  logic               kill = 1'b0;
  logic               trv_rst;
  logic [63:0]        trv_seed;
  logic [DW-1:0]      trv_data;
  logic               trv_valid;
  logic [NUM_REQ-1:0] gnt;
  logic [DW-1:0]      rnd_data;
  logic               busy;
  logic [CNT_W-1:0]   issue_cnt;

  prng_share_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .seed_in(seed_in), .reseed(reseed),
    .trv_rst(trv_rst), .trv_seed(trv_seed), .trv_data(trv_data), .trv_valid(trv_valid),
    .req(req), .gnt(gnt), .rnd_data(rnd_data), .busy(busy), .issue_cnt(issue_cnt)
  );

  // PRNG adapter model: loads on trv_rst, valid INIT_CYC cycles after trv_rst falls,
  // new distinct word every cycle (odd multiplier makes the step map a bijection).
  logic [63:0] p_seed = '0;
  int          p_cnt  = 0;
  logic        p_valid = 1'b0;
  logic [DW-1:0] p_data = '0;
  assign trv_valid = p_valid && !kill;
  assign trv_data  = p_data;

  always @(posedge clk) begin
    if (trv_rst === 1'b1) begin
      p_seed  <= trv_seed;
      p_cnt   <= 0;
      p_valid <= 1'b0;
      p_data  <= '0;
    end else begin
      p_cnt   <= p_cnt + 1;
      p_valid <= (p_cnt + 1 >= INIT_CYC);
      p_data  <= p_seed ^ (GOLD * 64'(p_cnt + 1));
    end
  end

  // Word the DUT could have captured at the most recent edge.
  logic [DW-1:0] word_at_edge = '0;
  always @(posedge clk) word_at_edge <= trv_data;

  // Reference model of the arbiter rules.
  int               m_phase = PH_SEED;
  int               m_rr    = 0;
  int               m_cnt   = 0;
  logic [NUM_REQ-1:0] e_gnt = '0;
  logic [DW-1:0]    e_data  = '0;
  logic [63:0]      e_seed  = '0;

  function automatic int pick(input logic [NUM_REQ-1:0] r, input int start);
    for (int k = 0; k < NUM_REQ; k++)
      if (r[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= PH_SEED;
      e_seed  <= seed_in;
      m_rr    <= 0;
      m_cnt   <= 0;
      e_gnt   <= '0;
      e_data  <= '0;
    end else begin
      if (m_phase == PH_RUN && !reseed && trv_valid && req != '0) begin
        e_gnt  <= NUM_REQ'(1) << pick(req, m_rr);
        e_data <= trv_data;
        m_rr   <= (pick(req, m_rr) + 1) % NUM_REQ;
        m_cnt  <= (m_cnt + 1) % (1 << CNT_W);
      end else begin
        e_gnt <= '0;
      end
      if (reseed) begin
        e_seed  <= seed_in;
        m_phase <= PH_SEED;
      end else if (m_phase == PH_SEED) begin
        m_phase <= PH_WAIT;
      end else if (m_phase == PH_WAIT && trv_valid) begin
        m_phase <= PH_RUN;
      end
    end
  end

  logic [VW-1:0] obs_vec;
  assign obs_vec = {gnt, rnd_data, issue_cnt, trv_rst, busy, trv_seed};

  function automatic logic [VW-1:0] exp_vec();
    return {e_gnt, e_data, CNT_W'(m_cnt), (m_phase == PH_SEED), (m_phase != PH_RUN), e_seed};
  endfunction

  function automatic logic [NUM_REQ-1:0] rotl(input logic [NUM_REQ-1:0] g);
    return {g[NUM_REQ-2:0], g[NUM_REQ-1]};
  endfunction

  int n_pass  = 0;
  int n_total = 0;

  task automatic test_reset();
    int rst_hi = 0;
    int first_gnt = -1;
    bit got = 1'b0;
    kill = 1'b0; reseed = 1'b0; req = 4'b0001;
    seed_in = 64'h0123_4567_89AB_CDEF; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({trv_rst, busy, gnt, issue_cnt, trv_seed} !== {1'b1, 1'b1, NUM_REQ'(0), CNT_W'(0), 64'h0123_4567_89AB_CDEF})
      $display("FAIL reset_state: got rst=%b busy=%b gnt=%b cnt=%0d seed=%h, exp 1 1 0000 0 0123456789abcdef",
               trv_rst, busy, gnt, issue_cnt, trv_seed);
    else n_pass++;
    for (int i = 0; i < 60 && !got; i++) begin
      if (i > 0) @(negedge clk);
      n_total++;
      if (obs_vec !== exp_vec()) $display("FAIL init_model: cyc %0d got %h exp %h", i, obs_vec, exp_vec());
      else n_pass++;
      if (trv_rst) rst_hi++;
      if (gnt != '0) begin
        got = 1'b1;
        first_gnt = i;
        n_total++;
        if (gnt !== 4'b0001 || rnd_data !== word_at_edge)
          $display("FAIL first_word: got gnt=%b data=%h, exp 0001 %h", gnt, rnd_data, word_at_edge);
        else n_pass++;
      end
    end
    n_total++;
    if (rst_hi !== 1) $display("FAIL trv_rst_pulse: got %0d cycles, exp 1", rst_hi);
    else n_pass++;
    n_total++;
    if (!got || first_gnt < 20) $display("FAIL init_wait: first grant at cycle %0d, exp >= 20", first_gnt);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int start = m_cnt;
    logic [NUM_REQ-1:0] prev = '0;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_total++;
      if (obs_vec !== exp_vec()) $display("FAIL rr_model: cyc %0d got %h exp %h", i, obs_vec, exp_vec());
      else n_pass++;
      n_total++;
      if (!$onehot(gnt) || (i > 0 && gnt !== rotl(prev)) || rnd_data !== word_at_edge)
        $display("FAIL rr_rotate: cyc %0d got gnt=%b data=%h, exp gnt=%b data=%h",
                 i, gnt, rnd_data, rotl(prev), word_at_edge);
      else n_pass++;
      prev = gnt;
    end
    req = '0;
    n_total++;
    if (issue_cnt !== CNT_W'(start + 8)) $display("FAIL rr_count: got %0d, exp %0d", issue_cnt, CNT_W'(start + 8));
    else n_pass++;
  endtask

  task automatic test_single_then_pair();
    logic [DW-1:0] seen[$];
    bit dup;
    req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dup = 1'b0;
      foreach (seen[j]) if (seen[j] === rnd_data) dup = 1'b1;
      n_total++;
      if (gnt !== 4'b0100 || dup || obs_vec !== exp_vec())
        $display("FAIL single_req: cyc %0d got gnt=%b dup=%b vec=%h, exp gnt=0100 dup=0 vec=%h",
                 i, gnt, dup, obs_vec, exp_vec());
      else n_pass++;
      seen.push_back(rnd_data);
    end
    req = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_total++;
      if (gnt !== ((i % 2 == 0) ? 4'b0001 : 4'b0100) || obs_vec !== exp_vec())
        $display("FAIL pair_alt: cyc %0d got gnt=%b, exp %b", i, gnt, (i % 2 == 0) ? 4'b0001 : 4'b0100);
      else n_pass++;
    end
    req = '0;
  endtask

  task automatic test_reseed();
    logic [NUM_REQ-1:0] last;
    bit resumed = 1'b0;
    req = 4'b1111;
    repeat (3) @(negedge clk);
    last = gnt;
    reseed = 1'b1;
    seed_in = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    reseed = 1'b0;
    n_total++;
    if ({gnt, trv_rst, busy, trv_seed} !== {NUM_REQ'(0), 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001})
      $display("FAIL reseed_start: got gnt=%b rst=%b busy=%b seed=%h, exp 0000 1 1 deadbeef00000001",
               gnt, trv_rst, busy, trv_seed);
    else n_pass++;
    for (int i = 0; i < 60 && !resumed; i++) begin
      @(negedge clk);
      n_total++;
      if (obs_vec !== exp_vec()) $display("FAIL reseed_model: cyc %0d got %h exp %h", i, obs_vec, exp_vec());
      else n_pass++;
      if (gnt != '0) begin
        resumed = 1'b1;
        n_total++;
        if (gnt !== rotl(last)) $display("FAIL reseed_ptr: got gnt=%b, exp %b", gnt, rotl(last));
        else n_pass++;
      end
    end
    n_total++;
    if (!resumed) $display("FAIL reseed_resume: got no grant in 60 cycles, exp a grant");
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    req = 4'b1111;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({gnt, issue_cnt, trv_rst} !== {NUM_REQ'(0), CNT_W'(0), 1'b1})
      $display("FAIL mid_reset: got gnt=%b cnt=%0d rst=%b, exp 0000 0 1", gnt, issue_cnt, trv_rst);
    else n_pass++;
    repeat (5) @(negedge clk);
    reseed = 1'b1;
    seed_in = {$urandom, $urandom};
    @(negedge clk);
    reseed = 1'b0;
    n_total++;
    if (trv_rst !== 1'b1 || trv_seed !== seed_in)
      $display("FAIL wait_reseed: got rst=%b seed=%h, exp 1 %h", trv_rst, trv_seed, seed_in);
    else n_pass++;
    for (int i = 0; i < 60 && busy; i++) begin
      @(negedge clk);
      n_total++;
      if (obs_vec !== exp_vec()) $display("FAIL wait_model: cyc %0d got %h exp %h", i, obs_vec, exp_vec());
      else n_pass++;
      if (busy && !trv_rst) waited++;
    end
    n_total++;
    if (waited !== INIT_CYC + 1 || busy) $display("FAIL init_restart: got %0d wait cycles busy=%b, exp %0d 0",
                                                  waited, busy, INIT_CYC + 1);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] prev_cnt = issue_cnt;
    bit saw = 1'b0;
    req = 4'b0010;
    for (int i = 0; i < 40 && !saw; i++) begin
      @(negedge clk);
      n_total++;
      if (obs_vec !== exp_vec()) $display("FAIL wrap_model: cyc %0d got %h exp %h", i, obs_vec, exp_vec());
      else n_pass++;
      if (gnt != '0 && prev_cnt == '1) begin
        saw = 1'b1;
        n_total++;
        if (issue_cnt !== '0) $display("FAIL cnt_wrap: got %0d, exp 0", issue_cnt);
        else n_pass++;
      end
      prev_cnt = issue_cnt;
    end
    n_total++;
    if (!saw) $display("FAIL wrap_seen: got no wrap in 40 cycles, exp one");
    else n_pass++;
    req = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req     = NUM_REQ'($urandom);
      kill    = ($urandom_range(0, 7) == 0);
      reseed  = ($urandom_range(0, 59) == 0);
      seed_in = {$urandom, $urandom};
      @(negedge clk);
      n_total++;
      if (obs_vec !== exp_vec()) $display("FAIL random_model: cyc %0d got %h exp %h", i, obs_vec, exp_vec());
      else n_pass++;
    end
    req = '0; kill = 1'b0; reseed = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_then_pair();
    test_reseed();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
